// File: rtl/alu_acc_scheduler.sv
// Two-requester accumulate scheduler.
// A single shared three-input adder (acc + x + y + cin) is time-shared between
// two packet sources. A round-robin pointer picks the winner. The grant is held
// until the winner's last beat. The packet total is then presented on a
// registered result port until the consumer takes it.
module alu_acc_scheduler #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_cin,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_cin,
  input  logic             req1_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_id,
  output logic [CNT_W-1:0] res_beats
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  state_t           state_reg;
  logic             ptr_reg;
  logic             grant_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic             sel_cin;
  logic             sel_valid;
  logic             sel_last;
  logic             accept;
  logic [WIDTH:0]   sum_full;
  logic [CNT_W-1:0] cnt_next;

  // Ready depends only on state and grant, never on the requester's valid.
  assign req0_ready = (state_reg == ACC) && !grant_reg;
  assign req1_ready = (state_reg == ACC) &&  grant_reg;

  // Operand mux in front of the shared adder, steered by the locked grant.
  assign sel_x     = grant_reg ? req1_x     : req0_x;
  assign sel_y     = grant_reg ? req1_y     : req0_y;
  assign sel_cin   = grant_reg ? req1_cin   : req0_cin;
  assign sel_valid = grant_reg ? req1_valid : req0_valid;
  assign sel_last  = grant_reg ? req1_last  : req0_last;
  assign accept    = (state_reg == ACC) && sel_valid;

  // A WIDTH+1 bit sum keeps the carry at bit WIDTH.
  // The second carry bit (WIDTH+1) is dropped by the truncation.
  assign sum_full = {1'b0, acc_reg} + {1'b0, sel_x} + {1'b0, sel_y}
                  + (WIDTH+1)'(sel_cin);

  // The beat count saturates instead of wrapping on long packets.
  assign cnt_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  // Scheduler FSM with registered result outputs.
  // res_cout doubles as the running carry register. It is cleared on grant and
  // updated on every accepted beat. It is only meaningful while res_valid is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      grant_reg <= 1'b0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
      res_beats <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_reg <= (req0_valid && req1_valid) ? ptr_reg : req1_valid;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            res_cout  <= 1'b0;
            state_reg <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_reg  <= sum_full[WIDTH-1:0];
            res_cout <= sum_full[WIDTH];
            cnt_reg  <= cnt_next;
            if (sel_last) begin
              state_reg <= DRAIN;
              res_valid <= 1'b1;
              res_data  <= sum_full[WIDTH-1:0];
              res_id    <= grant_reg;
              res_beats <= cnt_next;
            end
          end
        end
        DRAIN: begin
          if (res_ready) begin
            state_reg <= IDLE;
            res_valid <= 1'b0;
            ptr_reg   <= ~grant_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_acc_scheduler.md
ALU_ACC_SCHEDULER -- requirements
Module: alu_acc_scheduler

Interface
REQ-001 Parameter: WIDTH, 48, datapath width of operands, accumulator and result.
REQ-002 Parameter: CNT_W, 8, width of the beat counter.
REQ-003 Clocking is fixed: one clock, `clk`, and reset is synchronous and active-high, `reset`.
REQ-004 The block SHALL expose exactly the following ports, clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 beat valid.
- req0_ready  out  1  requester 0 beat accepted.
- req0_x  in  WIDTH  requester 0 X operand.
- req0_y  in  WIDTH  requester 0 Y operand.
- req0_cin  in  1  requester 0 carry-in.
- req0_last  in  1  final beat of requester 0 packet.
- req1_valid, req1_ready, req1_x, req1_y, req1_cin, req1_last: same widths and meanings for requester 1.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  WIDTH  accumulated sum.
- res_cout  out  1  carry-out of the final beat.
- res_id  out  1  requester that owned the packet.
- res_beats  out  CNT_W  beats in the packet, saturating.

Function
REQ-005 The block SHALL share one internal three-input adder, S = W + X + Y + CIN, between two requesters, with W fed back from the accumulator.
REQ-006 The FSM SHALL have three states: IDLE, ACC and DRAIN.
REQ-007 In IDLE, if any reqN_valid=1, the block SHALL grant the requester selected by a round-robin pointer, go to ACC next cycle, clear acc, cout and the beat count, and assert no ready that cycle.
REQ-008 Round-robin selection: if only one requester is valid it wins; if both are valid, the pointer's requester wins.
REQ-009 On each DRAIN->IDLE transition the pointer SHALL be set to the requester that was not granted.
REQ-010 In ACC, reqN_ready SHALL equal 1 only for the granted requester; the other ready SHALL be 0.
- The grant is locked until that requester's last beat is accepted.
REQ-011 A beat is accepted when the granted reqN_valid and reqN_ready are both 1.
- Accumulator update: acc <= (acc + x + y + cin) mod 2^WIDTH.
- Carry capture: the beat's bit WIDTH of the full-width sum goes to the cout register; bit WIDTH+1 is discarded.
REQ-012 The beat counter SHALL increment on each accepted beat and saturate at 2^CNT_W-1.
REQ-013 When a beat with last=1 is accepted, the FSM SHALL go to DRAIN next cycle.
- res_valid=1 one cycle after that beat, with res_data = the final acc, res_cout, res_id and res_beats.
REQ-014 In DRAIN, all reqN_ready SHALL be 0, and res_* SHALL hold stable until res_ready=1.
REQ-015 DRAIN with res_ready=1 SHALL move to IDLE next cycle and clear res_valid; no new grant is made in that same cycle.
REQ-016 A valid deasserting mid-packet in ACC SHALL stall the accumulation without losing the grant or the acc value.
REQ-017 A single-beat packet (first beat has last=1) SHALL produce res_beats=1.
REQ-018 Outputs SHALL be registered, except reqN_ready, which is decoded from state and grant only and never from reqN_valid.

Reset
REQ-019 With reset=1 at a clock edge, the next state SHALL be:
- state=IDLE, pointer=0.
- acc=0, cout=0, beat count=0.
- res_valid=0, res_data=0, res_cout=0, res_id=0, res_beats=0.
- req0_ready=0, req1_ready=0.
REQ-020 Reset SHALL take priority over every other event, including an accepted beat or an accepted result.
- A packet interrupted by reset is discarded, and no res_valid is produced for it.

Verification
REQ-021 Single requester:
- Stimulus: req0 beats (x=5, y=7, cin=1), (x=10, y=0, cin=0, last=1); res_ready=1.
- Required: res_data=23, res_cout=0, res_id=0, res_beats=2.
REQ-022 Wrap and carry:
- Stimulus: req1 single beat x=2^48-1, y=1, cin=0, last=1.
- Required: res_data=0, res_cout=1, res_id=1.
REQ-023 Contention after reset:
- Stimulus: req0_valid=1 and req1_valid=1 held, each packet 1 beat.
- Required: packet order is id 0, 1, 0, 1; req1_ready is never 1 while req0 is granted.
REQ-024 Backpressure:
- Stimulus: res_ready=0 for 5 cycles in DRAIN.
- Required: res_* stable, both ready=0; IDLE on the cycle after res_ready=1.
REQ-025 Stall and saturation:
- Stimulus: a req0_valid gap of 3 cycles mid-packet; a 300-beat packet of x=1, y=0.
- Required: the stall does not change the sum; res_data=300, res_beats=255.
REQ-026 Reset mid-packet:
- Stimulus: reset after 2 accepted beats, then a fresh 1-beat packet x=4.
- Required: no result is produced for the aborted packet; res_data=4.
